ibex_rvfi_trace_arb: RTL

- Merges the retirement streams of two Ibex cores into one trace sink, such as a single tracer or trace-dump port.
- Each core's RVFI retirement record is buffered in a per-source FIFO.
- The two FIFOs are arbitrated round-robin onto one valid/ready output tagged with the source ID.
- Flags dropped records and non-consecutive `rvfi_order` per source so the bench can detect lost or reordered retirements.

---
 rtl/ibex_rvfi_trace_arb.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ibex_rvfi_trace_arb.sv
// ---------------------------------------------------------------------------
// ibex_rvfi_trace_arb
//
// Merges the RVFI retirement streams of two Ibex cores into a single
// valid/ready trace stream. Each core's records land in a small per-source
// FIFO. The two FIFO heads are arbitrated round-robin, and the output is
// tagged with the source ID. Per-source sticky flags report dropped records
// (FIFO full) and non-consecutive rvfi_order values.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   trace_en_i           gate for incoming records (FIFOs keep draining)
//   clr_flags_i          pulse: clear overflow/order_err/drop counts and
//                        forget the last seen order
//   rvfi_*_i [1:0]       per-source retirement records (0 = core A, 1 = core B)
//   out_valid_o/out_ready_i  merged output handshake
//   out_src_o            source ID of the presented record
//   out_*_o              record fields of the presented record (0 when idle)
//   overflow_o[1:0]      sticky: a record was dropped because its FIFO was full
//   order_err_o[1:0]     sticky: a pushed order was not previous+1
//   drop_cnt_o[1:0]      saturating per-source dropped-record counts
// ---------------------------------------------------------------------------
module ibex_rvfi_trace_arb #(
    parameter int FifoDepth = 4,
    parameter int DropCntW  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     trace_en_i,
    input  logic                     clr_flags_i,
    input  logic [1:0]               rvfi_valid_i,
    input  logic [1:0][63:0]         rvfi_order_i,
    input  logic [1:0][31:0]         rvfi_pc_i,
    input  logic [1:0][31:0]         rvfi_insn_i,
    input  logic [1:0][4:0]          rvfi_rd_addr_i,
    input  logic [1:0][31:0]         rvfi_rd_wdata_i,
    input  logic [1:0]               rvfi_trap_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     out_src_o,
    output logic [63:0]              out_order_o,
    output logic [31:0]              out_pc_o,
    output logic [31:0]              out_insn_o,
    output logic [4:0]               out_rd_addr_o,
    output logic [31:0]              out_rd_wdata_o,
    output logic                     out_trap_o,
    output logic [1:0]               overflow_o,
    output logic [1:0]               order_err_o,
    output logic [1:0][DropCntW-1:0] drop_cnt_o
);

    localparam int AddrW = $clog2(FifoDepth);
    localparam int RecW  = 64 + 32 + 32 + 5 + 32 + 1;

    logic [1:0][RecW-1:0] head_rec;
    logic [1:0]           fifo_ne;
    logic [1:0]           fifo_full;
    logic [1:0]           rec_event;
    logic [1:0]           push;
    logic [1:0]           drop;
    logic [1:0]           pop;

    logic                 grant;
    logic                 grant_reg;
    logic                 prio_reg;
    logic                 lock_reg;
    logic                 out_valid;
    logic [RecW-1:0]      out_rec;

    // -----------------------------------------------------------------------
    // Arbitration. lock_reg remembers that the previous cycle presented a
    // record that was not accepted; in that case the same source stays
    // granted so the output cannot switch underneath a stalled sink. The
    // locked FIFO cannot have popped, so its head is unchanged as well.
    // -----------------------------------------------------------------------
    always_comb begin
        grant = 1'b0;
        if (lock_reg) begin
            grant = grant_reg;
        end else if (fifo_ne[0] && fifo_ne[1]) begin
            grant = prio_reg;
        end else begin
            grant = fifo_ne[1];
        end
    end

    assign out_valid = grant ? fifo_ne[1] : fifo_ne[0];

    always_comb begin
        pop = 2'b00;
        if (out_valid && out_ready_i) begin
            pop[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_reg  <= 1'b0;
            lock_reg  <= 1'b0;
            grant_reg <= 1'b0;
        end else begin
            lock_reg  <= out_valid && !out_ready_i;
            grant_reg <= grant;
            if (out_valid && out_ready_i) begin
                prio_reg <= !grant;
            end
        end
    end

    // Fields are forced to zero while idle so stale FIFO contents never
    // leak onto the trace port (and the port reads all-zero after reset).
    assign out_rec     = out_valid ? head_rec[grant] : '0;
    assign out_valid_o = out_valid;
    assign out_src_o   = grant;
    assign {out_order_o, out_pc_o, out_insn_o,
            out_rd_addr_o, out_rd_wdata_o, out_trap_o} = out_rec;

    // -----------------------------------------------------------------------
    // Per-source FIFO, order tracker and drop accounting.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        logic [RecW-1:0]     mem [FifoDepth];
        logic [AddrW:0]      wr_ptr_reg;
        logic [AddrW:0]      rd_ptr_reg;
        logic [AddrW:0]      level;
        logic [RecW-1:0]     in_rec;
        logic                has_prev_reg;
        logic [63:0]         last_order_reg;
        logic                order_bad;
        logic                overflow_reg;
        logic                order_err_reg;
        logic [DropCntW-1:0] drop_cnt_reg;
        logic [DropCntW-1:0] drop_cnt_base;
        logic [DropCntW-1:0] drop_cnt_next;

        // Pointers carry one extra wrap bit so full and empty are distinct.
        assign level          = wr_ptr_reg - rd_ptr_reg;
        assign fifo_full[gi]  = (level == (AddrW+1)'(FifoDepth));
        assign fifo_ne[gi]    = (level != '0);
        assign head_rec[gi]   = mem[rd_ptr_reg[AddrW-1:0]];

        assign in_rec = {rvfi_order_i[gi], rvfi_pc_i[gi], rvfi_insn_i[gi],
                         rvfi_rd_addr_i[gi], rvfi_rd_wdata_i[gi], rvfi_trap_i[gi]};

        // A full FIFO still accepts when it is popping in the same cycle.
        assign rec_event[gi] = rvfi_valid_i[gi] && trace_en_i;
        assign push[gi]      = rec_event[gi] && (!fifo_full[gi] || pop[gi]);
        assign drop[gi]      = rec_event[gi] && !push[gi];

        // A clear in the same cycle forgets the previous order, so the
        // record arriving with it is treated as the first one.
        assign order_bad = has_prev_reg && !clr_flags_i &&
                           (rvfi_order_i[gi] != last_order_reg + 64'd1);

        assign drop_cnt_base = clr_flags_i ? '0 : drop_cnt_reg;
        assign drop_cnt_next = (drop[gi] && (drop_cnt_base != '1)) ?
                               drop_cnt_base + DropCntW'(1) : drop_cnt_base;

        always_ff @(posedge clk_i) begin
            if (push[gi]) begin
                mem[wr_ptr_reg[AddrW-1:0]] <= in_rec;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wr_ptr_reg     <= '0;
                rd_ptr_reg     <= '0;
                has_prev_reg   <= 1'b0;
                last_order_reg <= '0;
                overflow_reg   <= 1'b0;
                order_err_reg  <= 1'b0;
                drop_cnt_reg   <= '0;
            end else begin
                if (push[gi]) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop[gi]) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end

                // Dropped records advance the tracker too, so a drop does
                // not show up later as an order gap.
                if (rec_event[gi]) begin
                    has_prev_reg   <= 1'b1;
                    last_order_reg <= rvfi_order_i[gi];
                end else if (clr_flags_i) begin
                    has_prev_reg   <= 1'b0;
                end

                // Set events win over a simultaneous clear.
                overflow_reg  <= (overflow_reg && !clr_flags_i) || drop[gi];
                order_err_reg <= (order_err_reg && !clr_flags_i) ||
                                 (push[gi] && order_bad);
                drop_cnt_reg  <= drop_cnt_next;
            end
        end

        assign overflow_o[gi]  = overflow_reg;
        assign order_err_o[gi] = order_err_reg;
        assign drop_cnt_o[gi]  = drop_cnt_reg;
    end

endmodule
